// File: rtl/ddr2_dq_window_cal.sv
// DDR2 read-capture calibration: sweeps each DQ bit's IDELAY, finds its data-eye
// edge(s) and parks the tap either a fixed shift from one edge or mid-way between two.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for registered cal_start
// BIT_INIT  | clear per-bit search state, capture reference dq level
// INC       | one increment pulse on the bit under calibration
// SETTLE    | wait SETTLE_CYC cycles for the delay line, then sample
// EDGE      | decide: keep searching, or compute the adjustment
// ADJ_DEC   | one decrement pulse per cycle until adjustment is used up
// ADJ_INC   | one increment pulse per cycle until adjustment is used up
// BIT_DONE  | report final_tap for this bit
// NEXT      | advance to the next bit or finish
// ALL_DONE  | all bits calibrated, hold while cal_start stays high
module ddr2_dq_window_cal #(
   parameter int DQ_WIDTH   = 8,
   parameter int TAP_W      = 6,
   parameter int MAX_TAP    = 63,
   parameter int SHIFT_TAPS = 16,
   parameter int SETTLE_CYC = 8,
   parameter int WIN_MODE   = 1,
   localparam int IDX_W     = (DQ_WIDTH > 1) ? $clog2(DQ_WIDTH) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cal_start,
   input  logic [DQ_WIDTH-1:0] dq_data,
   output logic [DQ_WIDTH-1:0] dlyce,
   output logic                dlyinc,
   output logic [IDX_W-1:0]    cal_bit_idx,
   output logic                bit_done,
   output logic [TAP_W-1:0]    final_tap,
   output logic [DQ_WIDTH-1:0] cal_err,
   output logic                cal_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_BIT_INIT, S_INC, S_SETTLE, S_EDGE,
      S_ADJ_DEC, S_ADJ_INC, S_BIT_DONE, S_NEXT, S_ALL_DONE
   } state_t;

   localparam logic [TAP_W-1:0] MAX_T       = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0] SHIFT_T     = TAP_W'(SHIFT_TAPS);
   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(DQ_WIDTH - 1);

   state_t state, state_nx;
   logic start_q;
   logic [IDX_W-1:0] idx, idx_nx;
   logic [TAP_W-1:0] tap_cnt, tap_nx, e1, e1_nx, adj_cnt, adj_nx;
   logic e1_found, e1_found_nx, prev, prev_nx, edge_q, edge_nx;
   logic [3:0] settle_cnt, settle_nx;
   logic [DQ_WIDTH-1:0] err_nx, bit_sel;
   logic dq_cur, adj_go, adj_down;
   logic [TAP_W-1:0] adj_amt, span, target;

   assign bit_sel = DQ_WIDTH'(1) << idx;
   assign dq_cur  = |(dq_data & bit_sel);
   assign span    = tap_cnt - e1;

   // Single-edge target around e1, clamped at the top of the tap range.
   always_comb begin
      target = e1 + SHIFT_T;
      if (e1 > SHIFT_T)
         target = e1 - SHIFT_T;
      else if (e1 > MAX_T - SHIFT_T)
         target = MAX_T;
   end

   always_comb begin
      state_nx    = state;
      idx_nx      = idx;
      tap_nx      = tap_cnt;
      e1_nx       = e1;
      e1_found_nx = e1_found;
      prev_nx     = prev;
      edge_nx     = edge_q;
      adj_nx      = adj_cnt;
      settle_nx   = settle_cnt;
      err_nx      = cal_err;
      adj_go      = 1'b0;
      adj_down    = 1'b0;
      adj_amt     = '0;
      case (state)
         S_IDLE: if (start_q) begin
            state_nx = S_BIT_INIT;
            idx_nx   = '0;
            err_nx   = '0;
         end
         S_BIT_INIT: begin
            tap_nx      = '0;
            e1_nx       = '0;
            e1_found_nx = 1'b0;
            edge_nx     = 1'b0;
            prev_nx     = dq_cur;
            state_nx    = S_INC;
         end
         S_INC: begin
            tap_nx    = tap_cnt + TAP_W'(1);
            settle_nx = '0;
            state_nx  = S_SETTLE;
         end
         S_SETTLE: if (settle_cnt == SETTLE_LAST) begin
            edge_nx  = dq_cur ^ prev;
            prev_nx  = dq_cur;
            state_nx = S_EDGE;
         end else begin
            settle_nx = settle_cnt + 4'd1;
         end
         S_EDGE: begin
            if (edge_q && !e1_found) begin
               e1_nx       = tap_cnt;
               e1_found_nx = 1'b1;
               // First edge at the last tap leaves no room for a second one.
               if (WIN_MODE == 0 || tap_cnt == MAX_T) begin
                  adj_go   = 1'b1;
                  adj_down = tap_cnt > SHIFT_T;
                  adj_amt  = SHIFT_T;
               end else begin
                  state_nx = S_INC;
               end
            end else if (edge_q && e1_found && span >= TAP_W'(2)) begin
               adj_go   = 1'b1;
               adj_down = 1'b1;
               adj_amt  = span >> 1;
            end else if (tap_cnt < MAX_T) begin
               state_nx = S_INC;
            end else if (!e1_found) begin
               err_nx   = cal_err | bit_sel;
               adj_go   = 1'b1;
               adj_down = 1'b1;
               adj_amt  = SHIFT_T;
            end else begin
               adj_go   = 1'b1;
               adj_down = 1'b1;
               adj_amt  = MAX_T - target;
            end
            if (adj_go) begin
               adj_nx = adj_amt;
               if (adj_amt == '0 || (adj_down && tap_cnt == '0) || (!adj_down && tap_cnt == MAX_T))
                  state_nx = S_BIT_DONE;
               else
                  state_nx = adj_down ? S_ADJ_DEC : S_ADJ_INC;
            end
         end
         S_ADJ_DEC: begin
            tap_nx = tap_cnt - TAP_W'(1);
            adj_nx = adj_cnt - TAP_W'(1);
            if (adj_cnt == TAP_W'(1) || tap_cnt == TAP_W'(1))
               state_nx = S_BIT_DONE;
         end
         S_ADJ_INC: begin
            tap_nx = tap_cnt + TAP_W'(1);
            adj_nx = adj_cnt - TAP_W'(1);
            if (adj_cnt == TAP_W'(1) || tap_cnt == MAX_T - TAP_W'(1))
               state_nx = S_BIT_DONE;
         end
         S_BIT_DONE: state_nx = S_NEXT;
         S_NEXT: if (idx == IDX_LAST) begin
            state_nx = S_ALL_DONE;
         end else begin
            idx_nx   = idx + IDX_W'(1);
            state_nx = S_BIT_INIT;
         end
         S_ALL_DONE: state_nx = S_ALL_DONE;
         default: state_nx = S_IDLE;
      endcase
      if (!start_q)
         state_nx = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         start_q    <= 1'b0;
         idx        <= '0;
         tap_cnt    <= '0;
         e1         <= '0;
         e1_found   <= 1'b0;
         prev       <= 1'b0;
         edge_q     <= 1'b0;
         adj_cnt    <= '0;
         settle_cnt <= '0;
         cal_err    <= '0;
      end else begin
         state      <= state_nx;
         start_q    <= cal_start;
         idx        <= idx_nx;
         tap_cnt    <= tap_nx;
         e1         <= e1_nx;
         e1_found   <= e1_found_nx;
         prev       <= prev_nx;
         edge_q     <= edge_nx;
         adj_cnt    <= adj_nx;
         settle_cnt <= settle_nx;
         cal_err    <= err_nx;
      end
   end

   assign dlyce       = (state == S_INC || state == S_ADJ_DEC || state == S_ADJ_INC) ? bit_sel : '0;
   assign dlyinc      = (state == S_INC || state == S_ADJ_INC);
   assign bit_done    = (state == S_BIT_DONE);
   assign final_tap   = bit_done ? tap_cnt : '0;
   assign cal_done    = (state == S_ALL_DONE);
   assign cal_bit_idx = idx;

endmodule

// File: tb/tb_ddr2_dq_window_cal.sv
// Bench for ddr2_dq_window_cal: one instance per window mode, each driven by a
// behavioural IDELAY/eye model, with per-bit expectations queued and checked on bit_done.
module tb_ddr2_dq_window_cal;
   localparam int W = 4;

   typedef struct {
      int idx;
      int fin;
      int err;
      int incs;
      int decs;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic cal_start = 1'b0;
   logic [W-1:0] dq [2];
   logic [W-1:0] dlyce [2];
   logic         dlyinc [2];
   logic [1:0]   idx [2];
   logic         bit_done [2];
   logic [5:0]   final_tap [2];
   logic [W-1:0] cal_err [2];
   logic         cal_done [2];

   int n_chk = 0;
   int n_err = 0;
   int tap [2][W];
   int lo [2][W];
   int hi [2][W];
   int base [2][W];
   int inc_cnt [2];
   int dec_cnt [2];
   int bits_seen [2];
   int exp_err [2];
   exp_t sb [2][$];

   // [run][instance][bit]; lo/hi >= 100 means no transition at that side
   int pat_lo [2][2][W] = '{'{'{10, 40, 100, 16}, '{12, 20, 100, 5}},
                            '{'{17, 1, 63, 100},  '{63, 2, 50, 3}}};
   int pat_hi [2][2][W] = '{'{'{99, 99, 100, 99}, '{44, 21, 100, 8}},
                            '{'{99, 99, 99, 100}, '{99, 4, 99, 99}}};
   int pat_bs [2][2][W] = '{'{'{0, 0, 1, 0}, '{0, 0, 0, 0}},
                            '{'{0, 0, 0, 0}, '{0, 1, 0, 0}}};

   always #5 clk = ~clk;

   ddr2_dq_window_cal #(.DQ_WIDTH(W), .WIN_MODE(0)) u_w0 (
      .clk(clk), .reset_n(reset_n), .cal_start(cal_start), .dq_data(dq[0]),
      .dlyce(dlyce[0]), .dlyinc(dlyinc[0]), .cal_bit_idx(idx[0]), .bit_done(bit_done[0]),
      .final_tap(final_tap[0]), .cal_err(cal_err[0]), .cal_done(cal_done[0]));

   ddr2_dq_window_cal #(.DQ_WIDTH(W), .WIN_MODE(1)) u_w1 (
      .clk(clk), .reset_n(reset_n), .cal_start(cal_start), .dq_data(dq[1]),
      .dlyce(dlyce[1]), .dlyinc(dlyinc[1]), .cal_bit_idx(idx[1]), .bit_done(bit_done[1]),
      .final_tap(final_tap[1]), .cal_err(cal_err[1]), .cal_done(cal_done[1]));

   always_comb begin
      for (int m = 0; m < 2; m++)
         for (int b = 0; b < W; b++)
            dq[m][b] = (base[m][b] != 0) ^ (tap[m][b] >= lo[m][b] && tap[m][b] < hi[m][b]);
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t expect_bit(input int mode, input int b, input int l, input int h);
      exp_t e;
      int tgt;
      e.idx = b;
      e.err = 0;
      if (l > 63) begin
         e.err = 1; e.fin = 47; e.incs = 63; e.decs = 16;
      end else if (mode == 0) begin
         if (l > 16) begin e.fin = l - 16; e.incs = l; e.decs = 16; end
         else begin e.fin = l + 16; e.incs = l + 16; e.decs = 0; end
      end else if (h <= 63 && h - l >= 2) begin
         e.incs = h; e.decs = (h - l) / 2; e.fin = h - e.decs;
      end else begin
         tgt = (l > 16) ? l - 16 : ((l + 16 > 63) ? 63 : l + 16);
         e.incs = 63; e.decs = 63 - tgt; e.fin = tgt;
      end
      return e;
   endfunction

   task automatic load_run(input int r);
      exp_t e;
      for (int m = 0; m < 2; m++) begin
         sb[m].delete();
         exp_err[m] = 0;
         inc_cnt[m] = 0;
         dec_cnt[m] = 0;
         bits_seen[m] = 0;
         for (int b = 0; b < W; b++) begin
            lo[m][b] = pat_lo[r][m][b];
            hi[m][b] = pat_hi[r][m][b];
            base[m][b] = pat_bs[r][m][b];
            tap[m][b] = 0;
            e = expect_bit(m, b, lo[m][b], hi[m][b]);
            sb[m].push_back(e);
            exp_err[m] |= e.err << b;
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      for (int m = 0; m < 2; m++) begin
         if (dlyce[m] != '0) begin
            if (sb[m].size() == 0) check_eq($sformatf("w%0d_dlyce_unexpected", m), int'(dlyce[m]), 0);
            else check_eq($sformatf("w%0d_dlyce_onehot", m), int'(dlyce[m]), 1 << sb[m][0].idx);
            for (int b = 0; b < W; b++)
               if (dlyce[m][b]) tap[m][b] += dlyinc[m] ? 1 : -1;
            if (dlyinc[m]) inc_cnt[m]++;
            else dec_cnt[m]++;
         end
         if (bit_done[m]) begin
            if (sb[m].size() == 0) begin
               check_eq($sformatf("w%0d_bit_done_unexpected", m), 1, 0);
            end else begin
               e = sb[m].pop_front();
               check_eq($sformatf("w%0d_bit_idx", m), int'(idx[m]), e.idx);
               check_eq($sformatf("w%0d_b%0d_final_tap", m, e.idx), int'(final_tap[m]), e.fin);
               check_eq($sformatf("w%0d_b%0d_model_tap", m, e.idx), tap[m][e.idx], e.fin);
               check_eq($sformatf("w%0d_b%0d_inc_pulses", m, e.idx), inc_cnt[m], e.incs);
               check_eq($sformatf("w%0d_b%0d_dec_pulses", m, e.idx), dec_cnt[m], e.decs);
               check_eq($sformatf("w%0d_b%0d_err", m, e.idx), int'(cal_err[m][e.idx]), e.err);
            end
            inc_cnt[m] = 0;
            dec_cnt[m] = 0;
            bits_seen[m]++;
         end
      end
   end

   task automatic wait_done(input string tag);
      int n = 0;
      while (!(cal_done[0] && cal_done[1]) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, int'(cal_done[0] && cal_done[1]), 1);
      for (int m = 0; m < 2; m++) begin
         check_eq($sformatf("%s_w%0d_cal_err", tag, m), int'(cal_err[m]), exp_err[m]);
         check_eq($sformatf("%s_w%0d_bits", tag, m), bits_seen[m], W);
         check_eq($sformatf("%s_w%0d_queue_left", tag, m), sb[m].size(), 0);
      end
   endtask

   task automatic check_quiet(input string tag, input int want_err0, input int want_err1);
      check_eq($sformatf("%s_w0_dlyce", tag), int'(dlyce[0]), 0);
      check_eq($sformatf("%s_w1_dlyce", tag), int'(dlyce[1]), 0);
      check_eq($sformatf("%s_w0_cal_done", tag), int'(cal_done[0]), 0);
      check_eq($sformatf("%s_w1_cal_done", tag), int'(cal_done[1]), 0);
      check_eq($sformatf("%s_w0_bit_done", tag), int'(bit_done[0]), 0);
      check_eq($sformatf("%s_w0_cal_err", tag), int'(cal_err[0]), want_err0);
      check_eq($sformatf("%s_w1_cal_err", tag), int'(cal_err[1]), want_err1);
   endtask

   initial begin
      int n;
      load_run(0);
      repeat (3) @(negedge clk);
      check_quiet("reset", 0, 0);
      check_eq("reset_w0_idx", int'(idx[0]), 0);
      check_eq("reset_w0_final_tap", int'(final_tap[0]), 0);
      check_eq("reset_w0_dlyinc", int'(dlyinc[0]), 0);
      reset_n = 1'b1;
      @(negedge clk);

      cal_start = 1'b1;
      wait_done("run_a");
      cal_start = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet("idle_a", 4, 4);

      load_run(1);
      cal_start = 1'b1;
      wait_done("run_b");
      cal_start = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet("idle_b", 8, 0);

      // abort while bit 0 of the single-edge instance is backing off
      load_run(1);
      cal_start = 1'b1;
      n = 0;
      while (!(dlyce[0] != '0 && !dlyinc[0]) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq("abort_reached_adj_dec", int'(dlyce[0] != '0 && !dlyinc[0]), 1);
      cal_start = 1'b0;
      repeat (2) @(negedge clk);
      check_quiet("abort", 0, 0);
      repeat (3) begin
         @(negedge clk);
         check_eq("abort_w0_dlyce_held", int'(dlyce[0]), 0);
      end

      // restart from bit 0, then reset in the middle of the run
      load_run(0);
      cal_start = 1'b1;
      n = 0;
      while (bits_seen[0] < 3 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_eq("restart_w0_bits_before_reset", int'(bits_seen[0] >= 3), 1);
      check_eq("restart_w0_err_before_reset", int'(cal_err[0]), 4);
      reset_n = 1'b0;
      @(negedge clk);
      check_quiet("mid_reset", 0, 0);
      check_eq("mid_reset_w0_idx", int'(idx[0]), 0);
      check_eq("mid_reset_w1_idx", int'(idx[1]), 0);
      load_run(1);
      @(negedge clk);
      check_eq("mid_reset_hold_w0_dlyce", int'(dlyce[0]), 0);
      reset_n = 1'b1;
      wait_done("run_after_reset");

      cal_start = 1'b0;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/ddr2_dq_window_cal.md
DDR2_DQ_WINDOW_CAL -- requirements
Module: ddr2_dq_window_cal

Interface
REQ-001 Parameter DQ_WIDTH, default 8: number of DQ bits calibrated in sequence, range 1..64.
REQ-002 Parameter TAP_W, default 6: width of the tap counter.
REQ-003 Parameter MAX_TAP, default 63: highest legal tap, at most 2^TAP_W-1.
REQ-004 Parameter SHIFT_TAPS, default 16: single-edge adjustment, min(32, T/4); must be less than MAX_TAP.
REQ-005 Parameter SETTLE_CYC, default 8: cycles waited after each search increment before sampling, range 2..15.
REQ-006 Parameter WIN_MODE, default 1: 0 = single-edge shift, 1 = two-edge window centering.
REQ-007 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-008 Port reset_n, input, 1: reset is synchronous and active-low.
REQ-009 Port cal_start, input, 1: level; high requests calibration, low aborts it.
REQ-010 Port dq_data, input, DQ_WIDTH: captured DQ bits.
REQ-011 Port dlyce, output, DQ_WIDTH: one-hot IDELAY enable for the bit under calibration.
REQ-012 Port dlyinc, output, 1: 1 = increment, 0 = decrement; valid only while dlyce is nonzero.
REQ-013 Port cal_bit_idx, output, clog2(DQ_WIDTH) (minimum 1): index of the bit under calibration.
REQ-014 Port bit_done, output, 1: one-cycle pulse when the current bit finishes.
REQ-015 Port final_tap, output, TAP_W: final tap of the finished bit; valid while bit_done is high.
REQ-016 Port cal_err, output, DQ_WIDTH: sticky flag per bit, set when that bit found no edge.
REQ-017 Port cal_done, output, 1: level, high once all bits are calibrated.

Function
REQ-018 cal_start shall be registered once; a FSM start is evaluated on the registered copy.
REQ-019 States: IDLE, BIT_INIT, INC, SETTLE, EDGE, ADJ_DEC, ADJ_INC, BIT_DONE, NEXT, ALL_DONE.
REQ-020 IDLE -> BIT_INIT when registered cal_start = 1; on entry, cal_bit_idx = 0 and cal_err is cleared.
REQ-021 BIT_INIT (1 cycle): clear tap_cnt, edge1 and edge2 state; store prev = dq_data[cal_bit_idx]; next state INC.
REQ-022 INC (1 cycle): dlyce[idx] = 1, dlyinc = 1, tap_cnt + 1; next state SETTLE.
REQ-023 SETTLE: counter clears on any dlyce; leave after exactly SETTLE_CYC cycles, then sample cur = dq_data[idx], set edge = (cur != prev), set prev = cur.
REQ-024 EDGE, first edge found: record e1 = tap_cnt.
REQ-025 EDGE, first edge, WIN_MODE = 0: if e1 > SHIFT_TAPS, ADJ_DEC for SHIFT_TAPS steps; otherwise ADJ_INC for SHIFT_TAPS steps.
REQ-026 EDGE, first edge, WIN_MODE = 1: continue INC to search for a second edge.
REQ-027 EDGE, second edge found (WIN_MODE = 1): record e2 = tap_cnt; ADJ_DEC for floor((e2-e1)/2) + (e2-e1 odd ? 0 : 0) = floor((e2-e1)/2) steps.
REQ-028 A second edge is valid only if e2 - e1 >= 2; otherwise it is ignored and prev is still updated.
REQ-029 EDGE, no edge and tap_cnt < MAX_TAP: go to INC.
REQ-030 EDGE, tap_cnt == MAX_TAP with no edge: set cal_err[idx]; ADJ_DEC for SHIFT_TAPS steps.
REQ-031 EDGE, tap_cnt == MAX_TAP with only e1 found (WIN_MODE = 1): apply the WIN_MODE = 0 rule relative to e1; net target = e1 ± SHIFT_TAPS, clamped to 0..MAX_TAP.
REQ-032 ADJ_DEC/ADJ_INC: one dlyce pulse per cycle with no settle; tap_cnt tracks each step; a zero-step count goes straight to BIT_DONE.
REQ-033 The tap counter shall never wrap: no INC at MAX_TAP, no DEC at 0.
REQ-034 BIT_DONE (1 cycle): bit_done = 1, final_tap = tap_cnt.
REQ-035 NEXT: if idx == DQ_WIDTH-1, go to ALL_DONE; otherwise idx + 1, then BIT_INIT.
REQ-036 ALL_DONE: cal_done = 1; remain there while cal_start = 1.
REQ-037 Registered cal_start = 0 in any state shall force IDLE on the next cycle; this overrides every other transition, including BIT_DONE.
REQ-038 In IDLE, cal_done = 0, dlyce = 0 and bit_done = 0; cal_err holds its value.
REQ-039 dlyce shall be at most one-hot, and nonzero only in INC, ADJ_DEC and ADJ_INC.

Reset
REQ-040 reset_n = 0 sampled at a clock edge shall, on the next cycle, give: state IDLE, dlyce = 0, dlyinc = 0, bit_done = 0, cal_done = 0, cal_err = 0, final_tap = 0, cal_bit_idx = 0, and all counters cleared.
REQ-041 Reset asserted mid-calibration shall take effect identically, with no further dlyce pulses.

Verification
REQ-042 WIN_MODE = 0, DQ_WIDTH = 1, edge at tap 10 -> 10 INC pulses, then 16 ADJ_INC pulses, then bit_done with final_tap = 26.
REQ-043 WIN_MODE = 0, edge at tap 40 -> 16 ADJ_DEC pulses, final_tap = 24.
REQ-044 WIN_MODE = 1, edges at taps 12 and 44 -> 16 ADJ_DEC pulses, final_tap = 28, cal_err = 0.
REQ-045 DQ stuck at 1 -> 63 INC pulses, cal_err[idx] = 1, final_tap = 47.
REQ-046 DQ_WIDTH = 4 with edges at distinct taps -> 4 bit_done pulses; dlyce one-hot at bits 0,1,2,3 in order; then cal_done = 1.
REQ-047 cal_start dropped mid-ADJ_DEC, or reset_n pulsed -> dlyce = 0 within 2 cycles and IDLE; re-raising cal_start restarts from bit 0.
